// File: rtl/txaxis_pkg.sv
// txaxis_pkg: shared widths, FSM states and tkeep helper for the TX AXIS drain stage
package txaxis_pkg;
    localparam int WIDTH = 256;
    localparam int KEEPW = 32;
    localparam int LENW  = 16;
    typedef enum logic [1:0] {IDLE, LEN_WAIT, STREAM} state_t;
    function automatic logic [31:0] keep_from_len(input logic [4:0] len);
        return (len == 5'd0) ? 32'hFFFF_FFFF : (32'd1 << len) - 32'd1;
    endfunction
endpackage

// File: rtl/txaxis_skid2.sv
// txaxis_skid2: two-entry buffer whose registered head drives the stream outputs
module txaxis_skid2 #(
    parameter int W = 289
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);
    logic [W-1:0] ent1;
    // head takes the incoming word when it would be the oldest; otherwise it advances from ent1
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            ent1 <= '0;
            occ  <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push && (occ == 2'd0 || (pop && occ == 2'd1)))
                head <= din;
            else if (pop && occ == 2'd2)
                head <= ent1;
            if (push && (pop ? occ == 2'd2 : occ == 2'd1))
                ent1 <= din;
        end
    end
endmodule

// File: rtl/txdata_axis_tx.sv
// txdata_axis_tx: drains length-framed packets from the TX data FIFO onto an AXI4-Stream master
module txdata_axis_tx #(
    parameter int WIDTH = txaxis_pkg::WIDTH,
    parameter int KEEPW = txaxis_pkg::KEEPW,
    parameter int LENW  = txaxis_pkg::LENW,
    parameter int PTR   = 10
) (
    input  logic             rdclk,
    input  logic             reset,
    input  logic             len_rdempty,
    output logic             len_rden,
    input  logic [LENW-1:0]  len_dataout,
    input  logic             fifo_rdempty,
    input  logic [PTR:0]     fifo_rdusedw,
    output logic             fifo_rden,
    input  logic [WIDTH-1:0] fifo_dataout,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [KEEPW-1:0] m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             dbg
);
    import txaxis_pkg::*;
    state_t state, nstate;
    logic [11:0] reads_left, outs_left, beats;
    logic [KEEPW-1:0] last_keep;
    logic [LENW:0] len_round;
    logic inflight, inflight_last, pop;
    logic [1:0] occ;
    logic [WIDTH+KEEPW:0] head, din;
    logic unused_rdusedw;
    assign unused_rdusedw = ^fifo_rdusedw;
    assign len_round = {1'b0, len_dataout} + (LENW+1)'(31);
    assign beats = 12'(len_round >> 5);
    assign din = {fifo_dataout, inflight_last ? last_keep : {KEEPW{1'b1}}, inflight_last};
    assign m_axis_tvalid = occ != 2'd0;
    assign pop = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata = head[WIDTH+KEEPW:KEEPW+1];
    assign m_axis_tkeep = head[KEEPW:1];
    assign m_axis_tlast = head[0] & m_axis_tvalid;
    // state register
    always_ff @(posedge rdclk) begin
        state <= reset ? IDLE : nstate;
    end
    // next state: a packet ends the cycle its tlast beat is accepted
    always_comb begin
        nstate = state == IDLE     ? (len_rdempty ? IDLE : LEN_WAIT)
               : state == LEN_WAIT ? (len_dataout == '0 ? IDLE : STREAM)
               : (pop && outs_left == 12'd1) ? IDLE : STREAM;
    end
    // FIFO pops; data reads are throttled so buffered plus in-flight words never exceed two
    always_comb begin
        len_rden  = !reset && state == IDLE && !len_rdempty;
        fifo_rden = !reset && state == STREAM && reads_left != 12'd0 && !fifo_rdempty &&
                    (({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
        dbg       = state == STREAM;
    end
    // beat counters, final-beat keep and the one-cycle read-latency tracker
    always_ff @(posedge rdclk) begin
        if (reset) begin
            reads_left    <= '0;
            outs_left     <= '0;
            last_keep     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= fifo_rden;
            inflight_last <= fifo_rden && reads_left == 12'd1;
            if (state == LEN_WAIT) begin
                reads_left <= beats;
                outs_left  <= beats;
                last_keep  <= KEEPW'(keep_from_len(len_dataout[4:0]));
            end else begin
                if (fifo_rden) reads_left <= reads_left - 12'd1;
                if (pop) outs_left <= outs_left - 12'd1;
            end
        end
    end
    txaxis_skid2 #(.W(WIDTH+KEEPW+1)) u_buf (
        .clk  (rdclk),
        .rst  (reset),
        .push (inflight),
        .pop  (pop),
        .din  (din),
        .head (head),
        .occ  (occ)
    );
endmodule

// File: tb/tb_txdata_axis_tx.sv
// tb_txdata_axis_tx: directed checks of the TX AXIS drain stage against FIFO models
module tb_txdata_axis_tx;
    logic rdclk = 1'b0, reset = 1'b1, len_rdempty = 1'b1, fifo_rdempty = 1'b1, m_axis_tready = 1'b1;
    logic len_rden, fifo_rden, m_axis_tlast, m_axis_tvalid, dbg;
    logic [15:0] len_dataout = '0;
    logic [10:0] fifo_rdusedw = '0;
    logic [255:0] fifo_dataout = '0, m_axis_tdata;
    logic [31:0] m_axis_tkeep;
    logic [15:0] len_q[$];
    logic [255:0] dat_q[$];
    logic [255:0] bd[$];
    logic [31:0] bk[$];
    logic bl[$];
    int bc[$];
    int cyc = 0, checks = 0, passes = 0;
    int n_rden, max_occ, unstable, lenrd_cyc, first_valid_cyc, ph, vsum, lsum;
    logic tr_pat = 1'b0, stall_pend = 1'b0, pl;
    logic [255:0] pd;
    logic [31:0] pk;

    txdata_axis_tx dut (
        .rdclk(rdclk), .reset(reset), .len_rdempty(len_rdempty), .len_rden(len_rden),
        .len_dataout(len_dataout), .fifo_rdempty(fifo_rdempty), .fifo_rdusedw(fifo_rdusedw),
        .fifo_rden(fifo_rden), .fifo_dataout(fifo_dataout), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .dbg(dbg)
    );

    always #5 rdclk = ~rdclk;

    // FIFO models: read data appears the cycle after the pop
    always @(posedge rdclk) begin
        cyc <= cyc + 1;
        if (len_rden && len_q.size() != 0) len_dataout <= len_q.pop_front();
        if (fifo_rden && dat_q.size() != 0) fifo_dataout <= dat_q.pop_front();
    end

    // stream monitor: beats, pops, latency, buffer depth and hold-under-stall
    always @(negedge rdclk) begin
        if (!reset) begin
            if (len_rden && lenrd_cyc < 0) lenrd_cyc = cyc;
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (fifo_rden) n_rden++;
            if (int'(dut.u_buf.occ) > max_occ) max_occ = int'(dut.u_buf.occ);
            if (stall_pend && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tlast !== pl))
                unstable++;
            if (m_axis_tvalid && m_axis_tready) begin
                bd.push_back(m_axis_tdata);
                bk.push_back(m_axis_tkeep);
                bl.push_back(m_axis_tlast);
                bc.push_back(cyc);
            end
            stall_pend = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pk = m_axis_tkeep;
            pl = m_axis_tlast;
        end
    end

    function automatic logic [255:0] w(input int i);
        return {8{32'hA500_0000 | 32'(i)}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic refresh();
        len_rdempty = len_q.size() == 0;
        fifo_rdempty = dat_q.size() == 0;
        fifo_rdusedw = 11'(dat_q.size());
    endtask

    task automatic tick();
        @(posedge rdclk);
        #1;
        if (tr_pat) begin
            m_axis_tready = (ph % 3 == 0);
            ph++;
        end
        refresh();
    endtask

    task automatic push_len(input logic [15:0] l);
        len_q.push_back(l);
        refresh();
    endtask

    task automatic push_word(input logic [255:0] d);
        dat_q.push_back(d);
        refresh();
    endtask

    task automatic clear();
        bd.delete();
        bk.delete();
        bl.delete();
        bc.delete();
        n_rden = 0;
        max_occ = 0;
        unstable = 0;
        lenrd_cyc = -1;
        first_valid_cyc = -1;
        stall_pend = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 400 && bd.size() < n; i++) tick();
        repeat (6) tick();
    endtask

    initial begin
        clear();
        repeat (3) tick();
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_tlast", 256'(m_axis_tlast), 256'(0));
        chk("rst_len_rden", 256'(len_rden), 256'(0));
        chk("rst_fifo_rden", 256'(fifo_rden), 256'(0));
        chk("rst_dbg", 256'(dbg), 256'(0));
        chk("rst_tdata", m_axis_tdata, 256'(0));
        chk("rst_tkeep", 256'(m_axis_tkeep), 256'(0));
        reset = 1'b0;
        tick();

        clear();
        push_word(w(1));
        push_word(w(2));
        push_len(16'd64);
        wait_beats(2);
        chk("len64_beats", 256'(bd.size()), 256'(2));
        chk("len64_latency", 256'(first_valid_cyc - lenrd_cyc), 256'(4));
        chk("len64_b2b", 256'(bc[1] - bc[0]), 256'(1));
        chk("len64_d0", bd[0], w(1));
        chk("len64_d1", bd[1], w(2));
        chk("len64_k0", 256'(bk[0]), 256'(32'hFFFF_FFFF));
        chk("len64_k1", 256'(bk[1]), 256'(32'hFFFF_FFFF));
        chk("len64_l0", 256'(bl[0]), 256'(0));
        chk("len64_l1", 256'(bl[1]), 256'(1));
        chk("len64_idle_dbg", 256'(dbg), 256'(0));

        clear();
        push_word(w(3));
        push_word(w(4));
        push_len(16'd33);
        wait_beats(2);
        chk("len33_beats", 256'(bd.size()), 256'(2));
        chk("len33_k0", 256'(bk[0]), 256'(32'hFFFF_FFFF));
        chk("len33_k1", 256'(bk[1]), 256'(32'h0000_0001));
        chk("len33_l1", 256'(bl[1]), 256'(1));
        chk("len33_d1", bd[1], w(4));

        clear();
        push_word(w(5));
        push_len(16'd1);
        wait_beats(1);
        chk("len1_beats", 256'(bd.size()), 256'(1));
        chk("len1_k", 256'(bk[0]), 256'(32'h0000_0001));
        chk("len1_l", 256'(bl[0]), 256'(1));
        chk("len1_d", bd[0], w(5));

        clear();
        push_word(w(6));
        push_len(16'd0);
        push_len(16'd32);
        wait_beats(1);
        chk("len0_beats", 256'(bd.size()), 256'(1));
        chk("len0_rden", 256'(n_rden), 256'(1));
        chk("len0_d", bd[0], w(6));
        chk("len0_k", 256'(bk[0]), 256'(32'hFFFF_FFFF));
        chk("len0_l", 256'(bl[0]), 256'(1));

        clear();
        ph = 0;
        tr_pat = 1'b1;
        for (int i = 7; i <= 10; i++) push_word(w(i));
        push_len(16'd128);
        wait_beats(4);
        tr_pat = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) tick();
        chk("bp_beats", 256'(bd.size()), 256'(4));
        for (int i = 0; i < 4; i++) chk($sformatf("bp_d%0d", i), bd[i], w(7 + i));
        lsum = 0;
        foreach (bl[i]) lsum += int'(bl[i]);
        chk("bp_tlast_count", 256'(lsum), 256'(1));
        chk("bp_l3", 256'(bl[3]), 256'(1));
        chk("bp_rden", 256'(n_rden), 256'(4));
        chk("bp_max_occ_le2", 256'(max_occ <= 2), 256'(1));
        chk("bp_stable", 256'(unstable), 256'(0));

        clear();
        push_word(w(11));
        push_len(16'd96);
        for (int i = 0; i < 100 && bd.size() < 1; i++) tick();
        vsum = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vsum += int'(m_axis_tvalid);
        end
        chk("gap_tvalid_low", 256'(vsum), 256'(0));
        chk("gap_dbg", 256'(dbg), 256'(1));
        push_word(w(12));
        push_word(w(13));
        wait_beats(3);
        chk("gap_beats", 256'(bd.size()), 256'(3));
        for (int i = 0; i < 3; i++) chk($sformatf("gap_d%0d", i), bd[i], w(11 + i));
        chk("gap_l2", 256'(bl[2]), 256'(1));
        chk("gap_k2", 256'(bk[2]), 256'(32'hFFFF_FFFF));

        clear();
        for (int i = 14; i <= 17; i++) push_word(w(i));
        push_len(16'd128);
        for (int i = 0; i < 100 && bd.size() < 1; i++) tick();
        chk("rstmid_beat2_valid", 256'(m_axis_tvalid), 256'(1));
        reset = 1'b1;
        tick();
        chk("rstmid_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rstmid_dbg", 256'(dbg), 256'(0));
        chk("rstmid_state", 256'(dut.state), 256'(txaxis_pkg::IDLE));
        reset = 1'b0;
        len_q.delete();
        dat_q.delete();
        refresh();
        tick();
        clear();
        push_word(w(20));
        push_len(16'd32);
        wait_beats(1);
        chk("post_rst_beats", 256'(bd.size()), 256'(1));
        chk("post_rst_d", bd[0], w(20));
        chk("post_rst_l", 256'(bl[0]), 256'(1));
        chk("post_rst_k", 256'(bk[0]), 256'(32'hFFFF_FFFF));
        chk("post_rst_rden", 256'(n_rden), 256'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
